// File: rtl/multi_digit_timer_counter.sv
// Cascaded multi-digit counter with per-digit maxima, runtime up/down
// direction, and a load/start/pause control FSM. A count that reaches its
// terminal value either wraps or halts in EXPIRED.
//
// Control handshake: there is no valid/ready flow control here. load_i,
// stop_i, start_i and tick_i are level-sampled qualifiers acted on at each
// rising edge. The priority is load > stop > start > tick, and each input
// applies only in the states where it is meaningful.
module multi_digit_timer_counter #(
    parameter int NUM_DIGITS = 4,
    parameter int WIDTH      = 4,
    parameter logic [NUM_DIGITS*WIDTH-1:0] DIGIT_MAX = 16'h5959
) (
    input  logic                        clk_i,
    input  logic                        reset_i,
    input  logic                        load_i,
    input  logic [NUM_DIGITS*WIDTH-1:0] load_value_i,
    input  logic                        start_i,
    input  logic                        stop_i,
    input  logic                        tick_i,
    input  logic                        up_i,
    input  logic                        wrap_i,
    output logic [NUM_DIGITS*WIDTH-1:0] count_o,
    output logic                        running_o,
    output logic                        expired_o,
    output logic                        term_count_o,
    output logic                        done_pulse_o,
    output logic [1:0]                  state_o
);

    localparam int CW = NUM_DIGITS * WIDTH;
    localparam logic [WIDTH-1:0] ONE = {{(WIDTH-1){1'b0}}, 1'b1};

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        RUN     = 2'd1,
        EXPIRED = 2'd2
    } state_t;

    state_t          state_q, state_d;
    logic [CW-1:0]   count_q, count_d;
    logic            done_q, done_d;

    logic [CW-1:0]   step_cnt;     // count after one tick in the current direction
    logic [CW-1:0]   clamp_val;    // load_value with each digit clamped to its max
    logic            all_term;     // current count sits at the terminal value
    logic            step_term;    // stepped count would sit at the terminal value
    logic            carry;
    logic [WIDTH-1:0] dmax, dcur, dnew, dterm, dld;

    // Per-digit datapath: cascaded step, terminal detection and load clamping.
    always_comb begin
        step_cnt  = count_q;
        clamp_val = '0;
        all_term  = 1'b1;
        step_term = 1'b1;
        carry     = 1'b1;
        dmax      = '0;
        dcur      = '0;
        dnew      = '0;
        dterm     = '0;
        dld       = '0;
        for (int i = 0; i < NUM_DIGITS; i++) begin
            dmax  = DIGIT_MAX[i*WIDTH +: WIDTH];
            dcur  = count_q[i*WIDTH +: WIDTH];
            dld   = load_value_i[i*WIDTH +: WIDTH];
            dterm = up_i ? dmax : '0;
            if (carry) begin
                if (up_i) dnew = (dcur == dmax) ? '0 : dcur + ONE;
                else      dnew = (dcur == '0) ? dmax : dcur - ONE;
            end else begin
                dnew = dcur;
            end
            step_cnt[i*WIDTH +: WIDTH]  = dnew;
            clamp_val[i*WIDTH +: WIDTH] = (dld > dmax) ? dmax : dld;
            // A digit steps only while every lower digit is at its terminal value.
            carry     = carry & (dcur == dterm);
            all_term  = all_term & (dcur == dterm);
            step_term = step_term & (dnew == dterm);
        end
    end

    // Control FSM next-state, next count and done pulse generation.
    always_comb begin
        state_d = state_q;
        count_d = count_q;
        done_d  = 1'b0;
        if (load_i) begin
            count_d = clamp_val;
            state_d = IDLE;
        end else if (stop_i && state_q == RUN) begin
            state_d = IDLE;
        end else if (start_i && state_q == IDLE) begin
            // Starting at terminal with no wrap has nothing to count.
            state_d = (all_term && !wrap_i) ? EXPIRED : RUN;
        end else if (tick_i && state_q == RUN) begin
            count_d = step_cnt;
            if (step_term) begin
                done_d = 1'b1;
                if (!wrap_i) state_d = EXPIRED;
            end
        end
    end

    // State, count and pulse registers with synchronous active-low reset.
    always_ff @(posedge clk_i) begin
        if (!reset_i) begin
            state_q <= IDLE;
            count_q <= '0;
            done_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            count_q <= count_d;
            done_q  <= done_d;
        end
    end

    assign count_o      = count_q;
    assign running_o    = (state_q == RUN);
    assign expired_o    = (state_q == EXPIRED);
    assign term_count_o = all_term;
    assign done_pulse_o = done_q;
    assign state_o      = state_q;

endmodule

// File: tb/tb_multi_digit_timer_counter.sv
// Bench for multi_digit_timer_counter: directed scenarios followed by
// randomized control traffic, checked each cycle against a mixed-radix
// integer model of the counter.
module tb_multi_digit_timer_counter;

  localparam int ND = 4;
  localparam int WD = 4;
  localparam logic [15:0] DMAX = 16'h5959;

  logic        clk;
  logic        reset_n;
  logic        load;
  logic [15:0] load_value;
  logic        start;
  logic        stop;
  logic        tick;
  logic        up;
  logic        wrap;
  logic [15:0] count;
  logic        running;
  logic        expired;
  logic        term_count;
  logic        done_pulse;
  logic [1:0]  state_dbg;

  int n_checks = 0;
  int n_fails  = 0;

  // model: count held as a single integer in mixed radix
  int radix[ND];
  int weight[ND];
  int total;
  int m_val;
  int m_mode;   // 0 idle, 1 run, 2 expired
  bit m_done;

  // ---------------- clock / reset ----------------
  initial clk = 1'b0;
  always #5 clk = ~clk;

  multi_digit_timer_counter #(
    .NUM_DIGITS(ND),
    .WIDTH(WD),
    .DIGIT_MAX(DMAX)
  ) dut (
    .clk_i(clk),
    .reset_i(reset_n),
    .load_i(load),
    .load_value_i(load_value),
    .start_i(start),
    .stop_i(stop),
    .tick_i(tick),
    .up_i(up),
    .wrap_i(wrap),
    .count_o(count),
    .running_o(running),
    .expired_o(expired),
    .term_count_o(term_count),
    .done_pulse_o(done_pulse),
    .state_o(state_dbg)
  );

  // ---------------- checker ----------------
  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_fails++;
      $display("FAIL %s: got %0h expected %0h at %0t", tag, obs, exp, $time);
    end
  endtask

  // ---------------- reference model ----------------
  function automatic logic [15:0] to_digits(input int v);
    logic [15:0] r;
    r = '0;
    for (int i = 0; i < ND; i++) r[i*WD +: WD] = 4'((v / weight[i]) % radix[i]);
    return r;
  endfunction

  function automatic int clamp_load(input logic [15:0] lv);
    int s;
    int d;
    s = 0;
    for (int i = 0; i < ND; i++) begin
      d = int'(lv[i*WD +: WD]);
      if (d > radix[i] - 1) d = radix[i] - 1;
      s += d * weight[i];
    end
    return s;
  endfunction

  function automatic bit at_term(input int v, input bit dir_up);
    return dir_up ? (v == total - 1) : (v == 0);
  endfunction

  task automatic model_edge();
    m_done = 1'b0;
    if (!reset_n) begin
      m_val  = 0;
      m_mode = 0;
    end else if (load) begin
      m_val  = clamp_load(load_value);
      m_mode = 0;
    end else if (stop && m_mode == 1) begin
      m_mode = 0;
    end else if (start && m_mode == 0) begin
      m_mode = (at_term(m_val, up) && !wrap) ? 2 : 1;
    end else if (tick && m_mode == 1) begin
      m_val = up ? (m_val + 1) % total : (m_val + total - 1) % total;
      if (at_term(m_val, up)) begin
        m_done = 1'b1;
        if (!wrap) m_mode = 2;
      end
    end
  endtask

  task automatic check_outputs();
    check("count", 32'(count), 32'(to_digits(m_val)));
    check("running", 32'(running), 32'(m_mode == 1));
    check("expired", 32'(expired), 32'(m_mode == 2));
    check("done_pulse", 32'(done_pulse), 32'(m_done));
    check("term_count", 32'(term_count), 32'(at_term(m_val, up)));
  endtask

  // ---------------- driver tasks ----------------
  // inputs are changed only around the falling edge
  task automatic cycle();
    @(posedge clk);
    model_edge();
    @(negedge clk);
    check_outputs();
  endtask

  task automatic idle_inputs();
    load  = 1'b0;
    start = 1'b0;
    stop  = 1'b0;
    tick  = 1'b0;
  endtask

  task automatic do_load(input logic [15:0] v);
    idle_inputs();
    load = 1'b1;
    load_value = v;
    cycle();
    load = 1'b0;
  endtask

  task automatic do_start();
    idle_inputs();
    start = 1'b1;
    cycle();
    start = 1'b0;
  endtask

  task automatic do_ticks(input int n);
    idle_inputs();
    tick = 1'b1;
    for (int i = 0; i < n; i++) cycle();
    tick = 1'b0;
  endtask

  // ---------------- stimulus ----------------
  initial begin
    logic [15:0] r;
    r = DMAX;
    total = 1;
    for (int i = 0; i < ND; i++) begin
      radix[i]  = int'(r[i*WD +: WD]) + 1;
      weight[i] = total;
      total     = total * radix[i];
    end
    m_val = 0; m_mode = 0; m_done = 1'b0;

    // reset dominates everything else
    reset_n = 1'b0;
    load = 1'b1; start = 1'b1; tick = 1'b1; stop = 1'b0;
    load_value = 16'h9999; up = 1'b0; wrap = 1'b0;
    @(negedge clk);
    cycle();
    cycle();
    check("reset_count", 32'(count), 32'h0);
    check("reset_state", 32'(state_dbg), 32'd0);
    reset_n = 1'b1;
    idle_inputs();

    // countdown from 01:00 with halt
    up = 1'b0; wrap = 1'b0;
    do_load(16'h0100);
    do_start();
    do_ticks(1);
    check("cd_first", 32'(count), 32'h0059);
    do_ticks(59);
    check("cd_zero", 32'(count), 32'h0000);
    check("cd_done", 32'(done_pulse), 32'd1);
    check("cd_expired", 32'(expired), 32'd1);
    do_ticks(1);
    check("cd_hold", 32'(count), 32'h0000);
    check("cd_done_once", 32'(done_pulse), 32'd0);

    // count up with wrap
    up = 1'b1; wrap = 1'b1;
    do_load(16'h5958);
    do_start();
    do_ticks(1);
    check("up_term", 32'(count), 32'h5959);
    check("up_done", 32'(done_pulse), 32'd1);
    do_ticks(1);
    check("up_wrap", 32'(count), 32'h0000);
    check("up_running", 32'(running), 32'd1);

    // clamp and priority
    do_load(16'h9999);
    check("clamp", 32'(count), 32'h5959);
    up = 1'b0; wrap = 1'b0;
    do_start();
    idle_inputs();
    load = 1'b1; tick = 1'b1; load_value = 16'h1234;
    cycle();
    idle_inputs();
    check("load_over_tick", 32'(count), 32'h1234);
    check("load_idle", 32'(running), 32'd0);
    do_start();
    stop = 1'b1; start = 1'b1;
    cycle();
    idle_inputs();
    check("stop_over_start", 32'(running), 32'd0);

    // pause and direction change
    do_load(16'h0010);
    do_start();
    do_ticks(3);
    check("pause_run", 32'(count), 32'h0007);
    stop = 1'b1;
    cycle();
    stop = 1'b0;
    do_ticks(5);
    check("pause_hold", 32'(count), 32'h0007);
    up = 1'b1;
    do_start();
    do_ticks(1);
    check("dir_up", 32'(count), 32'h0008);

    // start while already at terminal
    up = 1'b0; wrap = 1'b0;
    do_load(16'h0000);
    do_start();
    check("start_term_exp", 32'(expired), 32'd1);
    check("start_term_done", 32'(done_pulse), 32'd0);
    reset_n = 1'b0;
    cycle();
    reset_n = 1'b1;
    check("mid_reset", 32'(state_dbg), 32'd0);

    // randomized control traffic
    for (int c = 0; c < 3000; c++) begin
      reset_n = ($urandom_range(0, 199) != 0);
      load    = ($urandom_range(0, 99) < 3);
      stop    = ($urandom_range(0, 99) < 4);
      start   = ($urandom_range(0, 99) < 10);
      tick    = ($urandom_range(0, 99) < 60);
      if ($urandom_range(0, 99) < 5) up = ~up;
      if ($urandom_range(0, 199) == 0) wrap = ~wrap;
      case ($urandom_range(0, 3))
        0: load_value = 16'h0000;
        1: load_value = 16'h5959;
        2: load_value = 16'h0003 | (16'($urandom_range(0, 1)) << 8);
        default: load_value = 16'($urandom);
      endcase
      cycle();
    end
    idle_inputs();
    reset_n = 1'b1;

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fails);
    $finish;
  end

endmodule
